// File: rtl/ds_pkg.sv
// ds_pkg: shared ds helpers; index width for arbiter pointers and grant counter width
package ds_pkg;
  localparam int STAT_CNT_WIDTH = 16;
  function automatic int sclog2(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/ds_if.sv
// ds_if: valid/ready stream carrying a payload of type T
interface ds_if #(parameter type T = logic [7:0]);
  logic vld;
  logic rdy;
  T data;
  modport slv (input vld, data, output rdy);
  modport mst (output vld, data, input rdy);
endinterface

// File: rtl/ds_rr_pick.sv
// ds_rr_pick: first set bit of vld searching upward from ptr with wrap; one-hot and binary result
module ds_rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] vld,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] idx,
  output logic         any
);
  logic [N-1:0] rot;
  logic [W-1:0] off;
  logic [W:0]   sum;
  assign rot = N'({vld, vld} >> ptr);
  always_comb begin
    off = '0;
    for (int i = N - 1; i >= 0; i--)
      if (rot[i]) off = i[W-1:0];
  end
  assign sum = {1'b0, ptr} + {1'b0, off};
  assign idx = sum >= (W+1)'(N) ? W'(sum - (W+1)'(N)) : sum[W-1:0];
  assign any = |vld;
  assign gnt = any ? N'(1) << idx : '0;
endmodule

// File: rtl/ds_rr_arb.sv
// ds_rr_arb: round-robin merge of IN_CNT ds streams into one registered stream; DS_RR_ARB_STAT_EN adds grant counters
module ds_rr_arb import ds_pkg::*; #(
  parameter int  IN_CNT = 4,
  parameter type DTYPE  = logic [7:0],
  localparam int SRC_WIDTH = sclog2(IN_CNT)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  ds_if.slv                    if_slv [IN_CNT],
  ds_if.mst                    if_mst,
  output logic [SRC_WIDTH-1:0] o_src
`ifdef DS_RR_ARB_STAT_EN
  ,
  output logic [IN_CNT-1:0][STAT_CNT_WIDTH-1:0] o_grant_cnt
`endif
);
  logic [IN_CNT-1:0]    vld;
  logic [IN_CNT-1:0]    gnt;
  DTYPE                 data [IN_CNT];
  logic [SRC_WIDTH-1:0] ptr;
  logic [SRC_WIDTH-1:0] idx;
  logic                 any;
  logic                 out_vld;
  DTYPE                 out_data;
  logic [SRC_WIDTH-1:0] out_src;
  logic                 can_load;
  logic                 xfer;
  for (genvar i = 0; i < IN_CNT; i++) begin : g_in
    assign vld[i] = if_slv[i].vld;
    assign data[i] = if_slv[i].data;
    assign if_slv[i].rdy = gnt[i] & can_load & ~i_rst;
  end
  ds_rr_pick #(.N(IN_CNT), .W(SRC_WIDTH)) u_pick (
    .vld (vld),
    .ptr (ptr),
    .gnt (gnt),
    .idx (idx),
    .any (any)
  );
  assign can_load = !out_vld || if_mst.rdy;
  assign xfer = any && can_load && !i_rst;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      out_vld <= 1'b0;
      out_src <= '0;
      ptr <= '0;
    end else if (xfer) begin
      out_vld <= 1'b1;
      out_data <= data[idx];
      out_src <= idx;
      ptr <= idx == SRC_WIDTH'(IN_CNT - 1) ? '0 : idx + 1'b1;
    end else if (if_mst.rdy) begin
      out_vld <= 1'b0;
    end
  end
  assign if_mst.vld = out_vld;
  assign if_mst.data = out_data;
  assign o_src = out_src;
`ifdef DS_RR_ARB_STAT_EN
  always_ff @(posedge i_clk) begin
    for (int i = 0; i < IN_CNT; i++)
      if (i_rst) o_grant_cnt[i] <= '0;
      else if (xfer && gnt[i] && o_grant_cnt[i] != '1) o_grant_cnt[i] <= o_grant_cnt[i] + 1'b1;
  end
`endif
endmodule
